// File: rtl/mseq_burst_ctrl.sv
// Burst scheduler for an external Fibonacci LFSR m-sequence generator.
// Optional period self-check enabled by defining MSEQ_PERIOD_CHECK_EN.
`timescale 1ns/1ps
module mseq_burst_ctrl #(
  parameter int W    = 6,
  parameter int NP_W = 8
) (
  input  logic            sclk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    seed,
  input  logic [NP_W-1:0] n_periods,
  input  logic            abort,
  output logic            gen_load,
  output logic [W-1:0]    gen_seed,
  output logic            gen_en,
  input  logic [W-1:0]    gen_state,
  input  logic            gen_bit,
  output logic            out_bit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sop,
  output logic            out_eop,
  output logic            busy,
  output logic            done,
  output logic            err_cfg,
  output logic            period_err,
  output logic [NP_W-1:0] period_cnt
);

  localparam logic [W-1:0] LAST_BIT = W'((2 ** W) - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    seed_q;
  logic [W-1:0]    bit_cnt;
  logic [NP_W-1:0] n_q;
  logic            in_run;
  logic            transfer;
  logic            last_bit;
  logic            last_period;
  logic            accept;

  assign in_run      = (state == RUN);
  assign transfer    = in_run & out_ready;
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign last_period = (period_cnt == n_q - NP_W'(1));
  assign accept      = (state == IDLE) & start & (seed != '0);

  assign gen_en  = transfer;
  assign out_bit = in_run & gen_bit;
  assign out_sop = in_run & (bit_cnt == '0);
  assign out_eop = in_run & last_bit & last_period;

  always_comb begin
    state_nxt = state;
    gen_load  = 1'b0;
    gen_seed  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = (n_periods == '0) ? DONE : LOAD;
      end
      LOAD: begin
        gen_load  = 1'b1;
        gen_seed  = seed_q;
        busy      = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // abort wins over a coinciding final beat, so no done pulse
        if (abort)
          state_nxt = IDLE;
        else if (transfer && last_bit && last_period)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      seed_q     <= '0;
      n_q        <= '0;
      bit_cnt    <= '0;
      period_cnt <= '0;
      err_cfg    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && seed == '0)
        err_cfg <= 1'b1;
      if (accept) begin
        seed_q     <= seed;
        n_q        <= n_periods;
        err_cfg    <= 1'b0;
        bit_cnt    <= '0;
        period_cnt <= '0;
      end
      if (transfer) begin
        if (last_bit) begin
          bit_cnt    <= '0;
          period_cnt <= period_cnt + NP_W'(1);
        end else begin
          bit_cnt <= bit_cnt + W'(1);
        end
      end
    end
  end

`ifdef MSEQ_PERIOD_CHECK_EN
  always_ff @(posedge sclk) begin
    if (!rst_n)
      period_err <= 1'b0;
    else if (accept)
      period_err <= 1'b0;
    else if (in_run && bit_cnt == '0 && gen_state != seed_q)
      period_err <= 1'b1;
  end
`else
  logic gen_state_unused;
  assign gen_state_unused = ^gen_state;
  assign period_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mseq_burst_ctrl.sv
// Directed bench for mseq_burst_ctrl with a behavioural LFSR generator (poly 6'b101101).
`timescale 1ns/1ps
module tb_mseq_burst_ctrl;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] seed = '0;
  logic [7:0] n_periods = '0;
  logic       abort = 1'b0;
  logic       gen_load, gen_en;
  logic [5:0] gen_seed;
  logic [5:0] gen_state_m = '0;
  logic       out_bit, out_valid, out_sop, out_eop;
  logic       out_ready = 1'b0;
  logic       busy, done, err_cfg, period_err;
  logic [7:0] period_cnt;
  logic       corrupt = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sclk = ~sclk;

  mseq_burst_ctrl #(.W(6), .NP_W(8)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .n_periods  (n_periods),
    .abort      (abort),
    .gen_load   (gen_load),
    .gen_seed   (gen_seed),
    .gen_en     (gen_en),
    .gen_state  (gen_state_m),
    .gen_bit    (gen_state_m[0]),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg),
    .period_err (period_err),
    .period_cnt (period_cnt)
  );

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {^(s & 6'b101101), s[5:1]};
  endfunction

  always @(posedge sclk) begin
    if (gen_load)
      gen_state_m <= gen_seed;
    else if (gen_en)
      gen_state_m <= lfsr_step(gen_state_m) ^ {5'b0, corrupt};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_start(input logic [5:0] s, input logic [7:0] n);
    @(negedge sclk);
    seed = s;
    n_periods = n;
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    #1;
  endtask

  task automatic run_burst(input logic [5:0] s, input int n, input int rdy_pct,
                           input int abort_at, input int corrupt_at);
    logic [5:0] exp_st;
    int  beat, cyc;
    bit  fin, stalled, aborted;
    logic held;
    exp_st = s;
    beat = 0; cyc = 0; fin = 0; stalled = 0; aborted = 0; held = 1'b0;
    while (!fin && cyc < 1000) begin
      @(negedge sclk);
      cyc++;
      out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      abort     = (beat == abort_at);
      corrupt   = (beat == corrupt_at);
      if (abort || corrupt) out_ready = 1'b1;
      #1;
      if (cyc == 1) chk("valid_latency", out_valid, 1);
      chk("run_valid", out_valid, 1);
      chk("run_busy", busy, 1);
      if (stalled) chk("stall_hold", out_bit, held);
      if (out_valid) begin
        chk("beat_bit", out_bit, exp_st[0]);
        chk("beat_sop", out_sop, (beat % 63) == 0);
        chk("beat_eop", out_eop, beat == 63 * n - 1);
        stalled = !out_ready;
        held = out_bit;
        if (out_ready) begin
          exp_st = lfsr_step(exp_st) ^ {5'b0, corrupt};
          beat++;
        end
      end
      if (abort) aborted = 1;
      if (aborted || beat == 63 * n) fin = 1;
    end
    if (!fin) chk("burst_timeout", 0, 1);
    @(negedge sclk);
    out_ready = 1'b0;
    abort = 1'b0;
    corrupt = 1'b0;
    #1;
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_done", done, aborted ? 0 : 1);
    @(negedge sclk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("beat_count", beat, aborted ? abort_at + 1 : 63 * n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge sclk);
    #1;
    chk("reset_outputs", {gen_load, gen_seed, gen_en, out_bit, out_valid, out_sop, out_eop,
                          busy, done, err_cfg, period_err, period_cnt}, 0);
    rst_n = 1'b1;

    // single period, always ready
    do_start(6'b100000, 8'd1);
    chk("load_pulse", gen_load, 1);
    chk("load_seed", gen_seed, 6'b100000);
    chk("load_busy", busy, 1);
    chk("load_no_valid", out_valid, 0);
    run_burst(6'b100000, 1, 100, -1, -1);
    chk("t1_period_cnt", period_cnt, 1);

    // three periods with random backpressure
    do_start(6'b101011, 8'd3);
    run_burst(6'b101011, 3, 50, -1, -1);
    chk("t2_period_cnt", period_cnt, 3);

    // zero seed rejected, then valid start clears err_cfg
    do_start(6'b000000, 8'd1);
    chk("zero_seed_err", err_cfg, 1);
    chk("zero_seed_busy", busy, 0);
    chk("zero_seed_valid", out_valid, 0);
    chk("zero_seed_load", gen_load, 0);
    do_start(6'b000001, 8'd1);
    chk("err_cfg_cleared", err_cfg, 0);
    run_burst(6'b000001, 1, 100, -1, -1);

    // zero periods: done right after start, no beats
    do_start(6'd5, 8'd0);
    chk("n0_done", done, 1);
    chk("n0_valid", out_valid, 0);
    chk("n0_busy", busy, 0);
    chk("n0_load", gen_load, 0);
    chk("n0_period_cnt", period_cnt, 0);
    @(negedge sclk); #1;
    chk("n0_done_drop", done, 0);
    chk("n0_still_no_valid", out_valid, 0);

    // abort mid-period, then full restart, then abort on the last beat
    do_start(6'b100000, 8'd1);
    run_burst(6'b100000, 1, 100, 10, -1);
    chk("abort10_period_cnt", period_cnt, 0);
    do_start(6'b100000, 8'd1);
    run_burst(6'b100000, 1, 100, -1, -1);
    chk("restart_period_cnt", period_cnt, 1);
    do_start(6'b100000, 8'd1);
    run_burst(6'b100000, 1, 100, 62, -1);
    chk("abort62_period_cnt", period_cnt, 1);

    // generator corrupted mid-period; only the period check reacts
    do_start(6'b100000, 8'd2);
    chk("pcheck_clear_on_start", period_err, 0);
    run_burst(6'b100000, 2, 100, -1, 40);
    chk("pcheck_period_cnt", period_cnt, 2);
`ifdef MSEQ_PERIOD_CHECK_EN
    chk("period_err_set", period_err, 1);
`else
    chk("period_err_tied", period_err, 0);
`endif

    // reset in the middle of a run
    do_start(6'b110011, 8'd2);
    out_ready = 1'b1;
    repeat (5) @(negedge sclk);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge sclk); #1;
    chk("midrun_reset_outputs", {gen_load, gen_seed, gen_en, out_bit, out_valid, out_sop, out_eop,
                                 busy, done, err_cfg, period_err, period_cnt}, 0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge sclk); #1;
    chk("post_reset_no_done", done, 0);
    chk("post_reset_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
